// File: rtl/sng_pkg.sv
// rtl/sng_pkg.sv - shared types and constants for the stochastic number generator channel
package sng_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } sng_state_e;

   // Taps s[7], s[3], s[2], s[1]: maximal-length, period 255.
   localparam logic [7:0] LFSR_TAPS         = 8'b1000_1110;
   localparam logic [7:0] LFSR_DEFAULT_SEED = 8'h01;

   function automatic int clog2(input longint unsigned v);
      int r;
      r = 0;
      for (int i = 0; i < 63; i++) begin
         if ((64'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sng_lfsr8_en.sv
// rtl/sng_lfsr8_en.sv - 8-bit Fibonacci LFSR with enable and synchronous load
module sng_lfsr8_en
   import sng_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic       load_i,
   input  logic [7:0] seed_i,
   output logic [7:0] state_o
);

   logic [7:0] state_q;
   logic [7:0] state_d;

   // Load wins over enable so a fresh seed is never shifted in its load cycle.
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = seed_i;
      end else if (en_i) begin
         state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= LFSR_DEFAULT_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/sng_epoch_ctrl.sv
// rtl/sng_epoch_ctrl.sv - one-channel SNG epoch sequencer: seeds the LFSR, streams bits, counts ones
module sng_epoch_ctrl
   import sng_pkg::*;
#(
   parameter int unsigned EPOCH_LEN = 255,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             trig_i,
   input  logic             reset_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [7:0]       seed_i,
   input  logic [7:0]       value_i,
   output logic             busy_o,
   output logic             stoch_out_o,
   output logic             stoch_valid_o,
   output logic             done_o,
   output logic             aborted_o,
   output logic [CNT_W-1:0] result_o
);

   if (EPOCH_LEN < 1 || EPOCH_LEN > 65535 || clog2(EPOCH_LEN + 1) > CNT_W) begin : g_bad_param
      $error("sng_epoch_ctrl: EPOCH_LEN out of range or does not fit in CNT_W");
   end

   localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(EPOCH_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   sng_state_e       state_q, state_d;
   logic [7:0]       seed_q, seed_d;
   logic [7:0]       value_q, value_d;
   logic [CNT_W-1:0] ones_q, ones_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] result_q, result_d;
   logic             aborted_q, aborted_d;
   logic [CNT_W-1:0] ones_inc;
   logic [7:0]       lfsr_state;
   logic             hit;

   sng_lfsr8_en u_lfsr (
      .clk_i   (trig_i),
      .rst_ni  (reset_ni),
      .en_i    (state_q == ST_RUN),
      .load_i  (state_q == ST_LOAD),
      .seed_i  (seed_q),
      .state_o (lfsr_state)
   );

   assign hit      = (lfsr_state <= value_q);
   assign ones_inc = (hit && ones_q != '1) ? ones_q + CNT_ONE : ones_q;

   always_comb begin
      state_d       = state_q;
      seed_d        = seed_q;
      value_d       = value_q;
      ones_d        = ones_q;
      len_d         = len_q;
      result_d      = result_q;
      aborted_d     = aborted_q;
      busy_o        = 1'b0;
      stoch_out_o   = 1'b0;
      stoch_valid_o = 1'b0;
      done_o        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               seed_d  = (seed_i == 8'h00) ? LFSR_DEFAULT_SEED : seed_i;
               value_d = value_i;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            busy_o    = 1'b1;
            ones_d    = '0;
            len_d     = '0;
            aborted_d = 1'b0;
            state_d   = ST_RUN;
            if (abort_i) begin
               aborted_d = 1'b1;
               result_d  = '0;
               state_d   = ST_DONE;
            end
         end
         ST_RUN: begin
            busy_o        = 1'b1;
            stoch_out_o   = hit;
            stoch_valid_o = 1'b1;
            len_d         = len_q + CNT_ONE;
            // RESULT is registered on the way into DONE so it is valid alongside the pulse.
            if (abort_i) begin
               aborted_d = 1'b1;
               result_d  = ones_q;
               state_d   = ST_DONE;
            end else begin
               ones_d = ones_inc;
               if (len_q == LEN_LAST) begin
                  result_d = ones_inc;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge trig_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= ST_IDLE;
         seed_q    <= LFSR_DEFAULT_SEED;
         value_q   <= '0;
         ones_q    <= '0;
         len_q     <= '0;
         result_q  <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         seed_q    <= seed_d;
         value_q   <= value_d;
         ones_q    <= ones_d;
         len_q     <= len_d;
         result_q  <= result_d;
         aborted_q <= aborted_d;
      end
   end

   assign aborted_o = aborted_q;
   assign result_o  = result_q;

endmodule

// File: tb/tb_sng_epoch_ctrl.sv
// tb/tb_sng_epoch_ctrl.sv - scoreboard bench for sng_epoch_ctrl
module tb_sng_epoch_ctrl;

   localparam int EPOCH_LEN = 255;
   localparam int CNT_W     = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [7:0]       seed = 8'h00;
   logic [7:0]       value = 8'h00;
   logic             busy, stoch_out, stoch_valid, done, aborted;
   logic [CNT_W-1:0] result;

   typedef struct {
      int result;
      int aborted;
      int run_len;
      int ones;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   sng_epoch_ctrl #(.EPOCH_LEN(EPOCH_LEN), .CNT_W(CNT_W)) dut (
      .trig_i        (clk),
      .reset_ni      (rst_n),
      .start_i       (start),
      .abort_i       (abort),
      .seed_i        (seed),
      .value_i       (value),
      .busy_o        (busy),
      .stoch_out_o   (stoch_out),
      .stoch_valid_o (stoch_valid),
      .done_o        (done),
      .aborted_o     (aborted),
      .result_o      (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_exp(input int r, input int a, input int rl, input int o);
      exp_t e;
      e.result = r; e.aborted = a; e.run_len = rl; e.ones = o;
      exp_q.push_back(e);
   endtask

   task automatic go(input logic [7:0] s, input logic [7:0] v);
      @(posedge clk); #1;
      start = 1'b1; seed = s; value = v;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_n);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 600);
      check(name, n, exp_n);
   endtask

   task automatic wait_busy(input string name, input int exp_n);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < 20);
      check(name, n, exp_n);
   endtask

   initial begin : monitor
      int   run_len, ones_seen, last_result, last_aborted;
      exp_t e;
      run_len = 0; ones_seen = 0; last_result = 0; last_aborted = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run_len = 0; ones_seen = 0; last_result = 0; last_aborted = 0;
         end else begin
            if (!stoch_valid) check("stoch_zero_outside_run", stoch_out, 0);
            if (stoch_valid) begin
               run_len++;
               ones_seen += int'(stoch_out);
            end
            if (done) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_done actual=done required=no_done");
               end else begin
                  e = exp_q.pop_front();
                  check("done_result", result, e.result);
                  check("done_aborted", aborted, e.aborted);
                  check("done_run_len", run_len, e.run_len);
                  check("done_stream_ones", ones_seen, e.ones);
                  check("done_busy_low", busy, 0);
                  last_result = e.result;
                  last_aborted = e.aborted;
               end
               run_len = 0;
               ones_seen = 0;
            end else begin
               check("result_held", result, last_result);
               if (!busy) check("aborted_held", aborted, last_aborted);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin : driver
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_stoch_out", stoch_out, 0);
      check("rst_stoch_valid", stoch_valid, 0);
      check("rst_done", done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_result", result, 0);
      rst_n = 1'b1;

      // Full-period epochs: each LFSR value 1..255 appears once, so RESULT == VALUE.
      push_exp(0, 0, 255, 0);
      go(8'h01, 8'd0);
      wait_done("t1_latency", 257);

      push_exp(128, 0, 255, 128);
      go(8'h5A, 8'd128);
      wait_done("t2_latency", 257);

      push_exp(255, 0, 255, 255);
      go(8'h5A, 8'd255);
      wait_done("t3_latency", 257);

      push_exp(200, 0, 255, 200);
      go(8'h00, 8'd200);
      wait_done("t4_zero_seed", 257);

      // START pulse mid-RUN must not change the epoch.
      push_exp(10, 0, 255, 10);
      go(8'h33, 8'd10);
      repeat (20) @(posedge clk);
      #1;
      start = 1'b1; value = 8'd200;
      @(posedge clk); #1;
      start = 1'b0; value = 8'd10;
      wait_done("t6_start_ignored", 236);
      repeat (5) @(negedge clk);
      check("t6_no_requeue", busy, 0);

      // START held high: second LOAD two samples after first DONE.
      push_exp(100, 0, 255, 100);
      push_exp(50, 0, 255, 50);
      @(posedge clk); #1;
      start = 1'b1; seed = 8'h5A; value = 8'd100;
      @(posedge clk); #1;
      wait_done("t7_first", 257);
      value = 8'd50;
      wait_busy("t7_gap", 2);
      start = 1'b0;
      wait_done("t7_second", 256);

      // ABORT on the 10th RUN cycle.
      push_exp(9, 1, 10, 10);
      go(8'h5A, 8'd255);
      repeat (10) @(posedge clk);
      #1;
      check("t5_busy_in_run", busy, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_done("t5_done_next", 1);

      // Asynchronous reset mid-RUN.
      go(8'h5A, 8'd255);
      repeat (50) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("t8_busy", busy, 0);
      check("t8_stoch_valid", stoch_valid, 0);
      check("t8_stoch_out", stoch_out, 0);
      check("t8_done", done, 0);
      check("t8_aborted", aborted, 0);
      check("t8_result", result, 0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      push_exp(7, 0, 255, 7);
      go(8'hC3, 8'd7);
      wait_done("t9_after_reset", 257);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
